dcache_dmem_subsystem: RTL and testbench

//  CPU-facing data-memory subsystem: direct-mapped, write-back data cache in front of a
//  256-byte, word-organised, multi-cycle data memory. Serves the CPU load/store port

---
 rtl/dcache_dmem_subsystem.sv | 166 ++++++++++++++++
 tb/tb_dcache_dmem_subsystem.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dcache_dmem_subsystem.sv
// ============================================================================
// Module  : dcache_dmem_subsystem
// Brief   : Direct-mapped write-back data cache (8 x 4 B) over 64 x 32 data memory
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_dmem_subsystem #(
  parameter int MEM_LATENCY = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       READ,
  input  logic       WRITE,
  input  logic [7:0] ADDRESS,
  input  logic [7:0] WRITEDATA,
  output logic [7:0] READDATA,
  output logic       BUSYWAIT
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            valid_q [8];
  logic            dirty_q [8];
  logic [2:0]      tag_q   [8];
  logic [31:0]     data_q  [8];
  logic [31:0]     mem_q   [64];

  logic [2:0]      vtag_q;
  logic [2:0]      rtag_q;
  logic [2:0]      ridx_q;
  logic [31:0]     fill_q;
  logic [7:0]      rdata_q;

  logic [2:0]      tag;
  logic [2:0]      idx;
  logic [1:0]      off;
  logic            hit;
  logic            req;
  logic            in_idle;
  logic            rd_hit;
  logic            wr_hit;
  logic            miss_start;
  logic            cnt_last;
  logic [7:0]      sel_byte;

  assign tag        = ADDRESS[7:5];
  assign idx        = ADDRESS[4:2];
  assign off        = ADDRESS[1:0];
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign req        = READ | WRITE;
  assign in_idle    = (state_q == IDLE);
  // Simultaneous READ and WRITE is serviced as a store.
  assign wr_hit     = in_idle && hit && WRITE;
  assign rd_hit     = in_idle && hit && READ && !WRITE;
  assign miss_start = in_idle && req && !hit;
  assign cnt_last   = (cnt_q == CW'(MEM_LATENCY - 1));
  assign sel_byte   = data_q[idx][{off, 3'b000} +: 8];

  assign BUSYWAIT   = req && !(in_idle && hit);
  assign READDATA   = rd_hit ? sel_byte : rdata_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (miss_start) begin
          cnt_d   = '0;
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FETCH: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Miss address is captured on leaving IDLE so a dropped request still fills.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 8; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= 3'd0;
        data_q[i]  <= 32'd0;
      end
      for (int j = 0; j < 64; j++) begin
        mem_q[j] <= 32'd0;
      end
      vtag_q  <= 3'd0;
      rtag_q  <= 3'd0;
      ridx_q  <= 3'd0;
      fill_q  <= 32'd0;
      rdata_q <= 8'd0;
    end else begin
      if (rd_hit) begin
        rdata_q <= sel_byte;
      end
      if (wr_hit) begin
        data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
        dirty_q[idx]                    <= 1'b1;
      end
      if (miss_start) begin
        vtag_q <= tag_q[idx];
        rtag_q <= tag;
        ridx_q <= idx;
      end
      if (state_q == WRITEBACK && cnt_last) begin
        mem_q[{vtag_q, ridx_q}] <= data_q[ridx_q];
      end
      if (state_q == FETCH && cnt_last) begin
        fill_q <= mem_q[{rtag_q, ridx_q}];
      end
      if (state_q == UPDATE) begin
        data_q[ridx_q]  <= fill_q;
        tag_q[ridx_q]   <= rtag_q;
        valid_q[ridx_q] <= 1'b1;
        dirty_q[ridx_q] <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_dmem_subsystem.sv
// ============================================================================
// Module  : tb_dcache_dmem_subsystem
// Brief   : Directed self-checking bench for dcache_dmem_subsystem
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_dmem_subsystem;

  logic       CLK;
  logic       RESET;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  int checks;
  int errors;

  dcache_dmem_subsystem #(.MEM_LATENCY(5)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .READDATA  (READDATA),
    .BUSYWAIT  (BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request, count cycles with BUSYWAIT high, check stall and load byte.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [7:0] addr, input logic [7:0] wdata,
                        input int exp_stall, input logic [7:0] exp_rdata);
    int stall;
    @(posedge CLK); #1;
    READ      = rd;
    WRITE     = wr;
    ADDRESS   = addr;
    WRITEDATA = wdata;
    #1;
    stall = 0;
    while (BUSYWAIT && stall < 100) begin
      stall++;
      @(posedge CLK); #1;
    end
    check_int({tag, "_stall"}, stall, exp_stall);
    if (rd && !wr) check8({tag, "_rdata"}, READDATA, exp_rdata);
    @(posedge CLK); #1;
    READ  = 1'b0;
    WRITE = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    READ      = 1'b0;
    WRITE     = 1'b0;
    ADDRESS   = 8'h00;
    WRITEDATA = 8'h00;
    RESET     = 1'b0;
    #5 RESET  = 1'b1;

    @(posedge CLK); #1;
    check_int("rst_busywait", int'(BUSYWAIT), 0);
    check8("rst_readdata", READDATA, 8'h00);

    access("rd05_cold", 1'b1, 1'b0, 8'h05, 8'h00, 7, 8'h00);

    access("wr05", 1'b0, 1'b1, 8'h05, 8'hAB, 0, 8'h00);
    access("rd05_hit", 1'b1, 1'b0, 8'h05, 8'h00, 0, 8'hAB);
    access("rd04_hit", 1'b1, 1'b0, 8'h04, 8'h00, 0, 8'h00);

    access("rd25_dirty", 1'b1, 1'b0, 8'h25, 8'h00, 12, 8'h00);
    access("rd05_mem", 1'b1, 1'b0, 8'h05, 8'h00, 7, 8'hAB);

    access("wr9f_alloc", 1'b0, 1'b1, 8'h9F, 8'h3C, 7, 8'h00);
    access("rd9f_hit", 1'b1, 1'b0, 8'h9F, 8'h00, 0, 8'h3C);

    access("rdff_dirty", 1'b1, 1'b0, 8'hFF, 8'h00, 12, 8'h00);
    access("rd9f_mem", 1'b1, 1'b0, 8'h9F, 8'h00, 7, 8'h3C);

    // Start a clean miss, then reset while the fetch is in flight.
    @(posedge CLK); #1;
    READ    = 1'b1;
    ADDRESS = 8'h45;
    repeat (3) @(posedge CLK);
    #1;
    check_int("fetch_busy", int'(BUSYWAIT), 1);
    RESET = 1'b0;
    READ  = 1'b0;
    #1;
    check_int("midrst_busywait", int'(BUSYWAIT), 0);
    check8("midrst_readdata", READDATA, 8'h00);
    #3 RESET = 1'b1;

    access("rd05_postrst", 1'b1, 1'b0, 8'h05, 8'h00, 7, 8'h00);
    access("rd9f_postrst", 1'b1, 1'b0, 8'h9F, 8'h00, 7, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
